sr_dmem_arbiter: RTL and testbench

Arbitrates a single-port synchronous data RAM between two requesters: the CPU load/store port and an external loader/debug port (EXT). The block sits between the core's data memory interface and the RAM macro. It grants at most one access per cycle using round-robin priority. It tracks one outstanding read and returns its data to the correct requester one cycle after issue.

---
 rtl/sr_dmem_arbiter.sv | 112 +++++++++++
 tb/tb_sr_dmem_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sr_dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM port between the CPU and the EXT loader.
// Each read is issued in one cycle and its data is returned to the requester that issued it in the next cycle.
module sr_dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [DW/8-1:0] cpu_be,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  output logic [DW-1:0]   cpu_rdata,
  input  logic            ext_req,
  input  logic            ext_we,
  input  logic [DW/8-1:0] ext_be,
  input  logic [AW-1:0]   ext_addr,
  input  logic [DW-1:0]   ext_wdata,
  output logic            ext_gnt,
  output logic            ext_rvalid,
  output logic [DW-1:0]   ext_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RD_CPU = 2'd1;
  localparam logic [1:0] RD_EXT = 2'd2;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic       r_last_owner;
  logic       w_cpu_win;
  logic       w_ext_win;

  // Under contention the side that did not win last time gets the port; reset gates every grant.
  always_comb begin
    w_cpu_win = rst & cpu_req & (~ext_req | (r_last_owner == OWN_EXT));
    w_ext_win = rst & ext_req & (~cpu_req | (r_last_owner == OWN_CPU));
  end

  always_comb begin
    w_next_state = IDLE;
    if (w_cpu_win && !cpu_we) begin
      w_next_state = RD_CPU;
    end else if (w_ext_win && !ext_we) begin
      w_next_state = RD_EXT;
    end
  end

  // Reset to EXT ownership so the CPU wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_owner <= OWN_EXT;
    end else begin
      r_state <= w_next_state;
      if (w_cpu_win) begin
        r_last_owner <= OWN_CPU;
      end else if (w_ext_win) begin
        r_last_owner <= OWN_EXT;
      end
    end
  end

  always_comb begin
    cpu_gnt    = 1'b0;
    ext_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    ext_rvalid = 1'b0;
    cpu_rdata  = '0;
    ext_rdata  = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    if (rst) begin
      cpu_gnt    = w_cpu_win;
      ext_gnt    = w_ext_win;
      mem_en     = w_cpu_win | w_ext_win;
      mem_addr   = w_ext_win ? ext_addr : cpu_addr;
      mem_wdata  = w_ext_win ? ext_wdata : cpu_wdata;
      if (w_cpu_win) begin
        mem_we = cpu_we;
        mem_be = cpu_be;
      end else if (w_ext_win) begin
        mem_we = ext_we;
        mem_be = ext_be;
      end
      // Read data lanes stay zero unless their rvalid is high, keeping writeback muxes deterministic.
      cpu_rvalid = (r_state == RD_CPU);
      ext_rvalid = (r_state == RD_EXT);
      cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
      ext_rdata  = ext_rvalid ? mem_rdata : '0;
      busy       = (r_state != IDLE);
    end
  end

endmodule

// File: tb/tb_sr_dmem_arbiter.sv
// Bench for sr_dmem_arbiter: a behavioural RAM hangs off the mem_* port.
// A reference model predicts grants; predicted load data is queued at issue and compared one cycle later.
module tb_sr_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0]  cpu_be = 4'h0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [3:0]  ext_be = 4'h0;
  logic [31:0] ext_addr = 32'h0, ext_wdata = 32'h0;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  typedef struct packed {
    logic        isExt;
    logic [31:0] data;
  } rdExp_t;

  rdExp_t      expQ[$];
  logic [31:0] ram[256];
  logic [31:0] refMem[256];
  logic        modelLastExt;
  int          checks = 0;
  int          errors = 0;

  sr_dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_be(ext_be), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with byte-enable writes, driven only by the DUT's memory port.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= ram[mem_addr[9:2]];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic presetWord(input logic [31:0] addr, input logic [31:0] data);
    ram[addr[9:2]]    = data;
    refMem[addr[9:2]] = data;
  endtask

  // Compare one cycle's outputs against the model, then advance the model.
  task automatic checkCycle();
    rdExp_t      e;
    logic        expC, expE, wWe;
    logic [3:0]  wBe;
    logic [31:0] wAddr, wData;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, !e.isExt});
      checkOutput("ext_rvalid", {31'b0, ext_rvalid}, {31'b0, e.isExt});
      checkOutput("cpu_rdata", cpu_rdata, e.isExt ? 32'h0 : e.data);
      checkOutput("ext_rdata", ext_rdata, e.isExt ? e.data : 32'h0);
      checkOutput("busy", {31'b0, busy}, 32'h1);
    end else begin
      checkOutput("cpu_rvalid_idle", {31'b0, cpu_rvalid}, 32'h0);
      checkOutput("ext_rvalid_idle", {31'b0, ext_rvalid}, 32'h0);
      checkOutput("cpu_rdata_idle", cpu_rdata, 32'h0);
      checkOutput("ext_rdata_idle", ext_rdata, 32'h0);
      checkOutput("busy_idle", {31'b0, busy}, 32'h0);
    end
    expC = cpu_req && (!ext_req || modelLastExt);
    expE = ext_req && (!cpu_req || !modelLastExt);
    checkOutput("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, expC});
    checkOutput("ext_gnt", {31'b0, ext_gnt}, {31'b0, expE});
    checkOutput("mem_en", {31'b0, mem_en}, {31'b0, expC | expE});
    wWe   = expC ? cpu_we : (expE ? ext_we : 1'b0);
    wBe   = expC ? cpu_be : (expE ? ext_be : 4'h0);
    wAddr = expE ? ext_addr : cpu_addr;
    wData = expE ? ext_wdata : cpu_wdata;
    checkOutput("mem_we", {31'b0, mem_we}, {31'b0, wWe});
    checkOutput("mem_be", {28'b0, mem_be}, {28'b0, wBe});
    checkOutput("mem_addr", mem_addr, wAddr);
    if (expC || expE) begin
      checkOutput("mem_wdata", mem_wdata, wData);
      modelLastExt = expE;
      if (wWe) begin
        for (int b = 0; b < 4; b++) begin
          if (wBe[b]) refMem[wAddr[9:2]][8*b +: 8] = wData[8*b +: 8];
        end
      end else begin
        expQ.push_back('{isExt: expE, data: refMem[wAddr[9:2]]});
      end
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [3:0] cBe,
                               input logic [31:0] cAddr, input logic [31:0] cWd,
                               input logic eReq, input logic eWe, input logic [3:0] eBe,
                               input logic [31:0] eAddr, input logic [31:0] eWd);
    @(posedge clk);
    #1;
    cpu_req = cReq; cpu_we = cWe; cpu_be = cBe; cpu_addr = cAddr; cpu_wdata = cWd;
    ext_req = eReq; ext_we = eWe; ext_be = eBe; ext_addr = eAddr; ext_wdata = eWd;
    @(negedge clk);
    checkCycle();
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) presetWord(32'(i * 4), 32'h1000_0000 + 32'(i));
    presetWord(32'h10, 32'hDEADBEEF);
    presetWord(32'h20, 32'hFFFFFFFF);
    modelLastExt = 1'b1;

    // Outputs must be zero while reset is held, even with both sides requesting.
    cpu_req = 1'b1; ext_req = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'h55; cpu_be = 4'hF;
    #12;
    checkOutput("rst_cpu_gnt", {31'b0, cpu_gnt}, 32'h0);
    checkOutput("rst_ext_gnt", {31'b0, ext_gnt}, 32'h0);
    checkOutput("rst_mem_en", {31'b0, mem_en}, 32'h0);
    checkOutput("rst_mem_be", {28'b0, mem_be}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    cpu_req = 1'b0; ext_req = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;

    // First CPU load after reset.
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idleCycle();

    // EXT store with partial byte enables, then CPU reads the merged word.
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h1234ABCD);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    idleCycle();
    checkOutput("merged_word", refMem[8], 32'hFFFFABCD);

    // Back-to-back CPU loads overlap grant and rvalid.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 32'(i * 4), 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    end
    idleCycle();

    // EXT load, then reset asserted before the edge that would deliver it.
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
    @(posedge clk);
    #1;
    ext_req = 1'b0;
    checkOutput("pre_rst_ext_rvalid", {31'b0, ext_rvalid}, 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("midrd_ext_rvalid", {31'b0, ext_rvalid}, 32'h0);
    checkOutput("midrd_ext_rdata", ext_rdata, 32'h0);
    checkOutput("midrd_busy", {31'b0, busy}, 32'h0);
    expQ.delete();
    modelLastExt = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    idleCycle();

    // Continuous contention alternates, starting with the CPU.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 32'h40 + 32'(i * 4), 32'h0,
                    1'b1, 1'b0, 4'h0, 32'h80 + 32'(i * 4), 32'h0);
    end

    // Quiet period.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 32'h60, 32'h77, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    end

    // Mixed random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                    32'($urandom_range(0, 63) * 4), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                    32'($urandom_range(0, 63) * 4), $urandom);
    end
    idleCycle();
    idleCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
